alu_arbiter: RTL and testbench

- Shares one combinational 32-bit ALU between two requesters, each using a valid/ready handshake.
- Round-robin arbitration picks one request, registers its operands and opcode, and drives them onto the ALU.
- Captures the ALU result and zero flag, then returns them on a single response channel tagged with the requester ID.
- Sits between issue logic (two requesters) and the shared ALU instance.

---
 rtl/alu_arbiter.sv | 119 +++++++++++
 tb/tb_alu_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two valid/ready requesters
// and returns each result on a single response channel tagged with the owner's ID.
module alu_arbiter #(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3,
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*SEL_W-1:0] req_sel,
  input  logic [2*WIDTH-1:0] req_a,
  input  logic [2*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]   alu_in0,
  output logic [WIDTH-1:0]   alu_in1,
  output logic [SEL_W-1:0]   alu_selector,
  input  logic [WIDTH-1:0]   alu_out0,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               rsp_zero,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state;
  state_t state_nxt;
  logic   rr_ptr;
  logic   grant;
  logic   accept;
  logic   done;

  // A lone requester always wins; on contention rr_ptr names the favoured one.
  always_comb begin
    grant = (req_valid == 2'b11) ? rr_ptr : req_valid[1];
  end

  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (reset_n && (req_valid != 2'b00)) begin
          req_ready = grant ? 2'b10 : 2'b01;
          accept    = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        busy      = 1'b1;
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand capture on grant; the ALU-facing registers then hold until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      alu_in0      <= '0;
      alu_in1      <= '0;
      alu_selector <= '0;
      rsp_id       <= 1'b0;
    end else if (accept) begin
      alu_in0      <= grant ? req_a[WIDTH +: WIDTH] : req_a[0 +: WIDTH];
      alu_in1      <= grant ? req_b[WIDTH +: WIDTH] : req_b[0 +: WIDTH];
      alu_selector <= grant ? req_sel[SEL_W +: SEL_W] : req_sel[0 +: SEL_W];
      rsp_id       <= grant;
    end
  end

  // Result capture at the end of EXEC; held stable through RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_data <= '0;
      rsp_zero <= 1'b0;
    end else if (state == EXEC) begin
      rsp_data <= alu_out0;
      rsp_zero <= alu_zero;
    end
  end

  // Completion: count the op and hand priority to the requester that just lost.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_count <= '0;
      rr_ptr   <= 1'b0;
    end else if (done) begin
      op_count <= op_count + 1'b1;
      rr_ptr   <= ~rsp_id;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus a randomized phase,
// all cross-checked every cycle against a transaction-level model of the arbiter.
module tb_alu_arbiter;

  localparam int WIDTH = 32;
  localparam int SEL_W = 3;
  // Narrow counter so the wrap is reached in a few hundred operations.
  localparam int CNT_W = 8;

  logic               clk = 1'b0;
  logic               reset_n = 1'b1;
  logic [1:0]         req_valid = 2'b00;
  logic [1:0]         req_ready;
  logic [2*SEL_W-1:0] req_sel = '0;
  logic [2*WIDTH-1:0] req_a = '0;
  logic [2*WIDTH-1:0] req_b = '0;
  logic [WIDTH-1:0]   alu_in0;
  logic [WIDTH-1:0]   alu_in1;
  logic [SEL_W-1:0]   alu_selector;
  logic [WIDTH-1:0]   alu_out0;
  logic               alu_zero;
  logic               rsp_valid;
  logic               rsp_ready = 1'b1;
  logic               rsp_id;
  logic [WIDTH-1:0]   rsp_data;
  logic               rsp_zero;
  logic               busy;
  logic [CNT_W-1:0]   op_count;

  int checks = 0;
  int errors = 0;

  alu_arbiter #(.WIDTH(WIDTH), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_a(req_a), .req_b(req_b),
    .alu_in0(alu_in0), .alu_in1(alu_in1), .alu_selector(alu_selector),
    .alu_out0(alu_out0), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 shl, 6 signed less-than, 7 pass a.
  function automatic logic [WIDTH-1:0] alu_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic [SEL_W-1:0] s);
    case (s)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return a << b[4:0];
      3'd6: return {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: return a;
    endcase
  endfunction

  assign alu_out0 = alu_f(alu_in0, alu_in1, alu_selector);
  assign alu_zero = (alu_out0 == '0);

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: an operation is either absent or has an age in cycles since grant.
  bit               m_busy = 0;
  int               m_age = 0;
  int               m_pri = 0;
  int               m_id = 0;
  int               m_done = 0;
  logic [WIDTH-1:0] m_a = '0, m_b = '0, m_data = '0;
  logic [SEL_W-1:0] m_sel = '0;
  bit               m_zero = 0;

  function automatic int winner(input logic [1:0] v, input int pri);
    if (v == 2'b11) return pri;
    return (v == 2'b10) ? 1 : 0;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_busy = 0; m_age = 0; m_pri = 0; m_id = 0; m_done = 0;
        m_a = '0; m_b = '0; m_sel = '0; m_data = '0; m_zero = 0;
      end else if (m_busy) begin
        if (m_age == 1) begin
          m_data = alu_f(m_a, m_b, m_sel);
          m_zero = (m_data == '0);
          m_age = 2;
        end else if (rsp_ready) begin
          m_done++;
          m_pri = 1 - m_id;
          m_busy = 0;
        end
      end else if (req_valid != 2'b00) begin
        m_id  = winner(req_valid, m_pri);
        m_a   = req_a[m_id*WIDTH +: WIDTH];
        m_b   = req_b[m_id*WIDTH +: WIDTH];
        m_sel = req_sel[m_id*SEL_W +: SEL_W];
        m_busy = 1;
        m_age = 1;
      end
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  initial begin
    logic [1:0]       e_ready;
    logic [CNT_W-1:0] e_cnt;
    logic [127:0]     act, exp;
    forever begin
      @(negedge clk);
      e_ready = 2'b00;
      if (reset_n && !m_busy && req_valid != 2'b00)
        e_ready = (winner(req_valid, m_pri) == 1) ? 2'b10 : 2'b01;
      e_cnt = CNT_W'(m_done % (1 << CNT_W));
      act = {15'd0, req_ready, rsp_valid, rsp_id, rsp_zero, busy, op_count, alu_selector,
             rsp_data, alu_in0, alu_in1};
      exp = {15'd0, e_ready, (m_busy && m_age == 2), (m_id == 1), m_zero, m_busy, e_cnt, m_sel,
             m_data, m_a, m_b};
      chk("cycle_outputs", act, exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
  endtask

  task automatic set_req(input int i, input logic [SEL_W-1:0] s, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b);
    req_sel[i*SEL_W +: SEL_W] = s;
    req_a[i*WIDTH +: WIDTH]   = a;
    req_b[i*WIDTH +: WIDTH]   = b;
  endtask

  initial begin
    logic [1:0] hs;
    int n;
    #1;
    // Reset with both requesters asserting: nothing granted while reset is held.
    set_req(0, 3'd0, 32'd1, 32'd1);
    set_req(1, 3'd0, 32'd2, 32'd2);
    req_valid = 2'b11;
    reset_n = 1'b0;
    @(negedge clk);
    chk("rst_ready", 128'(req_ready), 128'(2'b00));
    chk("rst_outs", 128'({rsp_valid, busy, rsp_id, rsp_zero, op_count, rsp_data, alu_in0}), 128'(0));
    step();
    reset_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 128'(req_ready), 128'(2'b01));
    step();
    req_valid = 2'b00;
    repeat (4) step();

    // Single request from requester 1: 5 + 7.
    do_reset();
    set_req(1, 3'd0, 32'd5, 32'd7);
    req_valid = 2'b10;
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("single_ready", 128'(req_ready), 128'(2'b10));
    step();
    req_valid = 2'b00;
    @(negedge clk);
    chk("single_exec_busy", 128'({busy, rsp_valid}), 128'(2'b10));
    step();
    @(negedge clk);
    chk("single_rsp", 128'({rsp_valid, rsp_id, rsp_zero, rsp_data}), 128'({1'b1, 1'b1, 1'b0, 32'd12}));
    step();
    @(negedge clk);
    chk("single_count", 128'({rsp_valid, op_count}), 128'({1'b0, 8'd1}));

    // Continuous contention: grants alternate and one response lands every 3 cycles.
    do_reset();
    set_req(0, 3'd1, 32'd9, 32'd9);
    set_req(1, 3'd1, 32'd3, 32'd1);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rr_grant", 128'(req_ready), 128'((k % 2 == 0) ? 2'b01 : 2'b10));
      step();
      step();
      @(negedge clk);
      chk("rr_rsp", 128'({rsp_valid, rsp_id, rsp_zero, rsp_data}),
          (k % 2 == 0) ? 128'({1'b1, 1'b0, 1'b1, 32'd0}) : 128'({1'b1, 1'b1, 1'b0, 32'd2}));
      step();
    end
    req_valid = 2'b00;
    step();

    // Backpressure: response held for 10 cycles, the waiting request is not accepted.
    do_reset();
    rsp_ready = 1'b0;
    set_req(0, 3'd4, 32'h0000_F0F0, 32'h0000_0FF0);
    req_valid = 2'b01;
    step();
    step();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", 128'({rsp_valid, req_ready, rsp_id, rsp_data}), 128'({1'b1, 2'b00, 1'b0, 32'h0000_FF00}));
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 128'(req_ready), 128'(2'b00));
    step();
    @(negedge clk);
    chk("bp_next_grant", 128'({busy, req_ready}), 128'({1'b0, 2'b01}));
    step();
    req_valid = 2'b00;
    repeat (3) step();

    // Reset pulse during EXEC abandons the operation.
    do_reset();
    set_req(0, 3'd0, 32'd2, 32'd3);
    req_valid = 2'b01;
    step();
    req_valid = 2'b00;
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    chk("abort_clear", 128'({busy, rsp_valid, op_count}), 128'(0));
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("abort_no_rsp", 128'({rsp_valid, op_count}), 128'(0));
    end

    // Counter wrap after 2^CNT_W completions.
    do_reset();
    set_req(0, 3'd0, 32'd1, 32'd1);
    req_valid = 2'b01;
    n = 0;
    while (op_count != 8'd255 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("cnt_max", 128'(op_count), 128'(8'd255));
    n = 0;
    while (op_count == 8'd255 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("cnt_wrap", 128'(op_count), 128'(8'd0));
    step();
    req_valid = 2'b00;
    repeat (3) step();

    // Randomized traffic, checked only by the per-cycle model comparison.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (!req_valid[i] || hs[i]) begin
          req_valid[i] = ($urandom_range(0, 3) != 0);
          req_a[i*WIDTH +: WIDTH] = ($urandom_range(0, 1) != 0) ? $urandom() : $urandom_range(0, 15);
          req_b[i*WIDTH +: WIDTH] = ($urandom_range(0, 3) == 0) ? req_a[i*WIDTH +: WIDTH]
                                                                 : $urandom_range(0, 40);
          req_sel[i*SEL_W +: SEL_W] = SEL_W'($urandom_range(0, 7));
        end else if ($urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    repeat (5) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
